// File: rtl/trace_pkg.sv
// trace_pkg: shared definitions for the writeback trace monitor.
//   state_t  - monitor state encoding (IDLE, RUN, HALTED)
//   ENTRY_W  - trace entry width for the default 32-bit data / 5-bit register config
//   entry_w  - entry width for any DATA_W / REG_ADDR_W
//   sat_inc  - saturating increment for counters up to 64 bits wide
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam int ENTRY_W = 2 * 32 + 5;

  function automatic int entry_w(input int data_w, input int reg_addr_w);
    return 2 * data_w + reg_addr_w;
  endfunction

  // Holds at 2^w-1 instead of wrapping; callers cast to their width.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] max;
    max = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= max) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: first-word-fall-through FIFO holding trace entries.
//   clk, rst_n          clock, async active-low reset
//   clear               synchronous flush, wins over push/pop
//   push, push_data     write request; accepted when not full or when popping
//   pop                 consume head (ignored when empty)
//   head                current head entry, zero when empty
//   full, empty, level  occupancy status
module trace_fifo #(
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = 69
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [ENTRY_W-1:0]       push_data,
  input  logic                     pop,
  output logic [ENTRY_W-1:0]       head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr;
  logic               do_pop, do_push;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop frees the head slot on the same edge, so a full FIFO can still take a push.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: contents are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/writeback_trace_monitor.sv
// writeback_trace_monitor: logs register writebacks of the pipelined core into
// a drainable trace FIFO, keeps saturating cycle/stall/retire/drop counters and
// flags end-of-program when the PC sits on a self-jump.
//   clk, rst_n                      clock, async active-low reset
//   enable, clear                   start capture / synchronous flush to IDLE
//   pc, reg_write, write_reg,
//   write_data, stall               writeback tap and hazard-unit stall
//   rd_ready / rd_valid             trace drain handshake
//   rd_pc, rd_reg, rd_data          head entry (zero when empty)
//   level, overflow                 FIFO occupancy, sticky drop flag
//   drop_count, cycle_count,
//   stall_count, retire_count       saturating counters
//   halted                          end-of-program detected
module writeback_trace_monitor
  import trace_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 32,
  parameter int HALT_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    clear,
  input  logic [DATA_W-1:0]       pc,
  input  logic                    reg_write,
  input  logic [REG_ADDR_W-1:0]   write_reg,
  input  logic [DATA_W-1:0]       write_data,
  input  logic                    stall,
  input  logic                    rd_ready,
  output logic                    rd_valid,
  output logic [DATA_W-1:0]       rd_pc,
  output logic [REG_ADDR_W-1:0]   rd_reg,
  output logic [DATA_W-1:0]       rd_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic [CNT_W-1:0]        drop_count,
  output logic [CNT_W-1:0]        cycle_count,
  output logic [CNT_W-1:0]        stall_count,
  output logic [CNT_W-1:0]        retire_count,
  output logic                    halted
);

  localparam int EW = entry_w(DATA_W, REG_ADDR_W);
  localparam int SW = $clog2(HALT_CYCLES + 1);

  state_t            state, next_state;
  logic [DATA_W-1:0] prev_pc;
  logic [SW-1:0]     same_cnt, next_same;
  logic              in_run, capture, halt_hit, drop;
  logic              full, empty;
  logic [EW-1:0]     head;

  assign in_run  = (state == RUN);
  // Writes to $zero are architecturally invisible and never logged.
  assign capture = in_run && reg_write && (write_reg != '0);
  // Full implies non-empty, so a ready consumer always frees a slot this edge.
  assign drop    = capture && full && !rd_ready;

  trace_fifo #(.DEPTH(DEPTH), .ENTRY_W(EW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (capture),
    .push_data ({pc, write_reg, write_data}),
    .pop       (rd_ready),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  assign rd_valid = !empty;
  assign rd_pc    = head[EW-1 -: DATA_W];
  assign rd_reg   = head[DATA_W +: REG_ADDR_W];
  assign rd_data  = head[DATA_W-1:0];
  assign halted   = (state == HALTED);

  // Stalled cycles neither advance nor break the self-jump run.
  always_comb begin
    next_same = same_cnt;
    if (pc != prev_pc)  next_same = '0;
    else if (!stall)    next_same = same_cnt + 1'b1;
  end

  assign halt_hit = in_run && (next_same == SW'(HALT_CYCLES));

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (enable) next_state = RUN;
      RUN:     if (halt_hit) next_state = HALTED;
               else if (!enable) next_state = IDLE;
      HALTED:  next_state = HALTED;
      default: next_state = IDLE;
    endcase
    if (clear) next_state = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_pc  <= '0;
      same_cnt <= '0;
    end else if (clear) begin
      prev_pc  <= '0;
      same_cnt <= '0;
    end else if (state == IDLE && enable) begin
      same_cnt <= '0;
    end else if (in_run) begin
      prev_pc  <= pc;
      same_cnt <= next_same;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow     <= 1'b0;
      drop_count   <= '0;
      cycle_count  <= '0;
      stall_count  <= '0;
      retire_count <= '0;
    end else if (clear) begin
      overflow     <= 1'b0;
      drop_count   <= '0;
      cycle_count  <= '0;
      stall_count  <= '0;
      retire_count <= '0;
    end else if (in_run) begin
      cycle_count <= CNT_W'(sat_inc(64'(cycle_count), CNT_W));
      if (stall)   stall_count  <= CNT_W'(sat_inc(64'(stall_count), CNT_W));
      if (capture) retire_count <= CNT_W'(sat_inc(64'(retire_count), CNT_W));
      if (drop) begin
        overflow   <= 1'b1;
        drop_count <= CNT_W'(sat_inc(64'(drop_count), CNT_W));
      end
    end
  end

endmodule

// File: tb/tb_writeback_trace_monitor.sv
module tb_writeback_trace_monitor;

  localparam int DEPTH = 4;
  localparam int CNT_W = 6;
  localparam int HALT  = 4;
  localparam longint CMAX = (64'd1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst_n, enable, clear, reg_write, stall, rd_ready;
  logic [31:0] pc, write_data, rd_pc, rd_data;
  logic [4:0]  write_reg, rd_reg;
  logic        rd_valid, overflow, halted;
  logic [2:0]  level;
  logic [CNT_W-1:0] drop_count, cycle_count, stall_count, retire_count;

  writeback_trace_monitor #(
    .DATA_W(32), .REG_ADDR_W(5), .DEPTH(DEPTH), .CNT_W(CNT_W), .HALT_CYCLES(HALT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .pc(pc),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .stall(stall), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc),
    .rd_reg(rd_reg), .rd_data(rd_data), .level(level), .overflow(overflow),
    .drop_count(drop_count), .cycle_count(cycle_count), .stall_count(stall_count),
    .retire_count(retire_count), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: state 0=idle 1=run 2=halted
  int          m_state, m_lvl, m_same;
  longint      m_cyc, m_stl, m_ret, m_drop;
  bit          m_ovf;
  logic [31:0] m_prev;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic longint satp(input longint x);
    return (x < CMAX) ? x + 1 : x;
  endfunction

  task automatic model_reset();
    m_state = 0; m_lvl = 0; m_same = 0; m_prev = '0; m_ovf = 0;
    m_cyc = 0; m_stl = 0; m_ret = 0; m_drop = 0;
    exp_q.delete();
  endtask

  task automatic check_outputs();
    chk("level", level, m_lvl);
    chk("rd_valid", rd_valid, m_lvl > 0);
    chk("overflow", overflow, m_ovf);
    chk("halted", halted, m_state == 2);
    chk("drop_count", drop_count, m_drop);
    chk("cycle_count", cycle_count, m_cyc);
    chk("stall_count", stall_count, m_stl);
    chk("retire_count", retire_count, m_ret);
    if (m_lvl == 0) chk("rd_empty_zero", {rd_pc, rd_reg, rd_data}, 0);
  endtask

  // One clock: check current state, drive inputs, advance model to the next edge.
  task automatic step(input bit en, input bit clr, input bit rw, input logic [4:0] wr,
                      input logic [31:0] wd, input logic [31:0] pc_i,
                      input bit st, input bit rdy);
    bit pop, pushed;
    ent_t e;
    @(negedge clk);
    check_outputs();
    enable = en; clear = clr; reg_write = rw; write_reg = wr; write_data = wd;
    pc = pc_i; stall = st; rd_ready = rdy;
    if (clr) begin
      model_reset();
    end else begin
      pop = rdy && (m_lvl > 0);
      pushed = 0;
      if (m_state == 0) begin
        if (en) begin m_state = 1; m_same = 0; end
      end else if (m_state == 1) begin
        m_cyc = satp(m_cyc);
        if (st) m_stl = satp(m_stl);
        if (pc_i != m_prev) m_same = 0;
        else if (!st) m_same++;
        m_prev = pc_i;
        if (rw && wr != 0) begin
          m_ret = satp(m_ret);
          if (m_lvl == DEPTH && !pop) begin
            m_drop = satp(m_drop);
            m_ovf = 1;
          end else begin
            e.pc = pc_i; e.r = wr; e.d = wd;
            exp_q.push_back(e);
            pushed = 1;
          end
        end
        if (m_same == HALT) m_state = 2;
        else if (!en) m_state = 0;
      end
      m_lvl = m_lvl + int'(pushed) - int'(pop);
    end
  endtask

  // Monitor: whenever the DUT shows a head that is about to be consumed, compare it.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && !clear && rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_entry", rd_pc, 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          chk("rd_pc", rd_pc, e.pc);
          chk("rd_reg", rd_reg, e.r);
          chk("rd_data", rd_data, e.d);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] cur_pc;
    rst_n = 0; enable = 0; clear = 0; reg_write = 0; write_reg = 0;
    write_data = 0; pc = 0; stall = 0; rd_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    cur_pc = 32'h0;

    // Three writes, the $zero one must vanish; drain afterwards.
    step(1, 0, 0, 0, 0, 32'h0, 0, 0);
    step(1, 0, 1, 5'd8, 32'h11, 32'h0, 0, 0);
    step(1, 0, 1, 5'd0, 32'h22, 32'h4, 0, 0);
    step(1, 0, 1, 5'd2, 32'h33, 32'h8, 0, 0);
    step(0, 0, 0, 0, 0, 32'hC, 0, 1);
    repeat (3) step(0, 0, 0, 0, 0, 32'hC, 0, 1);
    chk("two_entry_retire", retire_count, 2);

    // Overflow: 6 writes into a 4-deep FIFO, then write+pop while full.
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 32'h100, 0, 0);
    for (int i = 0; i < 6; i++)
      step(1, 0, 1, 5'(i + 1), $urandom, 32'h104 + 32'(4 * i), 0, 0);
    step(1, 0, 1, 5'd9, 32'h99, 32'h200, 0, 1);
    step(0, 0, 0, 0, 0, 32'h204, 0, 0);
    chk("ovf_level", level, 4);
    chk("ovf_drop", drop_count, 2);
    repeat (5) step(0, 0, 0, 0, 0, 32'h204, 0, 1);

    // Self-jump halt with stalls interleaved, writes continuing.
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 32'h3C, 0, 1);
    for (int i = 0; i < 8; i++)
      step(1, 0, 1, 5'd3, 32'(i), 32'h40, (i == 2 || i == 5), 1);
    chk("halted_self_jump", halted, 1);
    // Clear in HALTED with simultaneous pop and capture request.
    step(1, 1, 1, 5'd4, 32'h55, 32'h40, 0, 1);
    step(0, 0, 0, 0, 0, 32'h40, 0, 0);
    chk("clear_halted", halted, 0);

    // Saturation: changing PC, no clear, long run.
    step(1, 0, 0, 0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 80; i++)
      step(1, 0, $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
           32'(4 * (i + 1)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
    step(1, 0, 0, 0, 0, 32'h1000, 0, 1);
    chk("cycle_saturated", cycle_count, CMAX);

    // Randomized traffic with occasional clears and an asynchronous reset.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) < 4) cur_pc = {26'($urandom_range(0, 15)), 2'b00};
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom,
           cur_pc, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 4));
      if (i == 700) begin
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 32'h500, 0, 0);
        for (int k = 0; k < 5; k++)
          step(1, 0, 1, 5'(k + 1), $urandom, 32'h504 + 32'(4 * k), 0, 0);
        @(negedge clk);
        #3 rst_n = 0;
        #1;
        chk("rst_level", level, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_halted", halted, 0);
        chk("rst_counts", {drop_count, cycle_count, stall_count, retire_count}, 0);
        chk("rst_rd", {rd_pc, rd_reg, rd_data}, 0);
        model_reset();
        enable = 0; clear = 0; reg_write = 0; rd_ready = 0; stall = 0;
        @(negedge clk);
        rst_n = 1;
      end
    end

    step(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (8) step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("drained_queue", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
